// File: rtl/alu_issue_ctrl.sv
// Single-request ALU issue controller: decodes one instruction, drives the
// ALU for one cycle and returns result, zero flag and branch decision.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_instr,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_rt,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_br_taken,
    output logic        rsp_illegal
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE} br_t;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_NOR = 4'b1100;

    state_t state, state_nxt;
    br_t    kind;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_sx;
    logic [31:0] imm_zx;
    logic        dec_legal;
    logic [3:0]  dec_ctrl;
    logic [31:0] dec_in2;
    br_t         dec_kind;
    logic        hs;
    logic        unused_instr;

    assign opcode       = req_instr[31:26];
    assign funct        = req_instr[5:0];
    assign imm_sx       = {{16{req_instr[15]}}, req_instr[15:0]};
    assign imm_zx       = {16'h0000, req_instr[15:0]};
    assign unused_instr = ^req_instr[25:16];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign hs        = req_valid & req_ready;

    always_comb begin
        dec_legal = 1'b1;
        dec_ctrl  = C_AND;
        dec_in2   = req_rt;
        dec_kind  = BR_NONE;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21: dec_ctrl = C_ADD;
                    6'h22, 6'h23: dec_ctrl = C_SUB;
                    6'h24:        dec_ctrl = C_AND;
                    6'h25:        dec_ctrl = C_OR;
                    6'h27:        dec_ctrl = C_NOR;
                    6'h2A:        dec_ctrl = C_SLT;
                    default:      dec_legal = 1'b0;
                endcase
            end
            6'h08, 6'h09, 6'h23, 6'h2B: begin
                dec_ctrl = C_ADD;
                dec_in2  = imm_sx;
            end
            6'h0A: begin
                dec_ctrl = C_SLT;
                dec_in2  = imm_sx;
            end
            6'h0C: begin
                dec_ctrl = C_AND;
                dec_in2  = imm_zx;
            end
            6'h0D: begin
                dec_ctrl = C_OR;
                dec_in2  = imm_zx;
            end
            6'h04: begin
                dec_ctrl = C_SUB;
                dec_kind = BR_EQ;
            end
            6'h05: begin
                dec_ctrl = C_SUB;
                dec_kind = BR_NE;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = dec_legal ? ISSUE : RESP;
            ISSUE:   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ALU operand registers self-clear so they are only non-zero in ISSUE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1      <= '0;
            alu_in2      <= '0;
            alu_ctrl     <= C_AND;
            kind         <= BR_NONE;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_br_taken <= 1'b0;
            rsp_illegal  <= 1'b0;
        end else begin
            alu_in1  <= '0;
            alu_in2  <= '0;
            alu_ctrl <= C_AND;
            if (hs) begin
                kind <= dec_legal ? dec_kind : BR_NONE;
                if (dec_legal) begin
                    alu_in1  <= req_rs;
                    alu_in2  <= dec_in2;
                    alu_ctrl <= dec_ctrl;
                end else begin
                    rsp_result   <= '0;
                    rsp_zero     <= 1'b0;
                    rsp_br_taken <= 1'b0;
                    rsp_illegal  <= 1'b1;
                end
            end
            if (state == ISSUE) begin
                rsp_result   <= alu_out;
                rsp_zero     <= alu_zero;
                rsp_br_taken <= (kind == BR_EQ) ? alu_zero :
                                (kind == BR_NE) ? ~alu_zero : 1'b0;
                rsp_illegal  <= 1'b0;
            end
            if (state == RESP && rsp_ready) begin
                rsp_result   <= '0;
                rsp_zero     <= 1'b0;
                rsp_br_taken <= 1'b0;
                rsp_illegal  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_instr = '0;
    logic [31:0] req_rs = '0;
    logic [31:0] req_rt = '0;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_br_taken;
    logic        rsp_illegal;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_instr(req_instr), .req_rs(req_rs), .req_rt(req_rt),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_br_taken(rsp_br_taken), .rsp_illegal(rsp_illegal)
    );

    always_comb begin
        alu_out = '0;
        case (alu_ctrl)
            4'b0000: alu_out = alu_in1 & alu_in2;
            4'b0001: alu_out = alu_in1 | alu_in2;
            4'b0010: alu_out = alu_in1 + alu_in2;
            4'b0110: alu_out = alu_in1 - alu_in2;
            4'b0111: alu_out = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
            4'b1100: alu_out = ~(alu_in1 | alu_in2);
            default: alu_out = '0;
        endcase
    end
    assign alu_zero = (alu_out == 32'h0);

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [3:0]  ctrl;
        logic [31:0] in2;
        logic [31:0] result;
        logic        zero;
        logic        br;
        logic        ill;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] s,
                        input logic [31:0] t, input logic rr);
        @(negedge clk);
        req_valid = 1'b1;
        req_instr = i;
        req_rs    = s;
        req_rt    = t;
        rsp_ready = rr;
        tick();
        req_valid = 1'b0;
        req_instr = 32'hFFFF_FFFF;
        req_rs    = ~s;
        req_rt    = ~t;
    endtask

    initial begin
        //        instr         rs            rt            ctrl   in2           result        z     br    ill
        vecs[0]  = '{32'h00221820, 32'd5,        32'd7,        4'h2, 32'd7,        32'd12,       1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h2000FFFF, 32'd1,        32'd0,        4'h2, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b0};
        vecs[2]  = '{32'h34008000, 32'h00010000, 32'd0,        4'h1, 32'h00008000, 32'h00018000, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h10000000, 32'd9,        32'd9,        4'h6, 32'd9,        32'd0,        1'b1, 1'b1, 1'b0};
        vecs[4]  = '{32'h14000000, 32'd9,        32'd9,        4'h6, 32'd9,        32'd0,        1'b1, 1'b0, 1'b0};
        vecs[5]  = '{32'h00000022, 32'd3,        32'd10,       4'h6, 32'd10,       32'hFFFFFFF9, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h0000002A, 32'hFFFFFFFF, 32'd1,        4'h7, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h00000027, 32'hF0F0F0F0, 32'h0F0F0F00, 4'hC, 32'h0F0F0F00, 32'h0000000F, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h00000024, 32'hFF00FF00, 32'h0FF00FF0, 4'h0, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h30008001, 32'hFFFFFFFF, 32'd0,        4'h0, 32'h00008001, 32'h00008001, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'h2800FFFF, 32'd0,        32'd0,        4'h7, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b0};
        vecs[11] = '{32'h14000000, 32'd1,        32'd2,        4'h6, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{32'h10000000, 32'd1,        32'd2,        4'h6, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{32'h8C000004, 32'h00000100, 32'd0,        4'h2, 32'h00000004, 32'h00000104, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{32'h00000000, 32'd3,        32'd4,        4'h0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1};

        #2;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst alu_in1", alu_in1, 32'd0);
        chk("rst rsp_result", rsp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 15; k++) begin
            send(vecs[k].instr, vecs[k].rs, vecs[k].rt, 1'b1);
            if (!vecs[k].ill) begin
                chk($sformatf("v%0d ctrl", k), 32'(alu_ctrl), 32'(vecs[k].ctrl));
                chk($sformatf("v%0d in1", k), alu_in1, vecs[k].rs);
                chk($sformatf("v%0d in2", k), alu_in2, vecs[k].in2);
                chk($sformatf("v%0d issue rsp_valid", k), 32'(rsp_valid), 32'd0);
                chk($sformatf("v%0d issue req_ready", k), 32'(req_ready), 32'd0);
                tick();
            end
            chk($sformatf("v%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("v%0d result", k), rsp_result, vecs[k].result);
            chk($sformatf("v%0d zero", k), 32'(rsp_zero), 32'(vecs[k].zero));
            chk($sformatf("v%0d br", k), 32'(rsp_br_taken), 32'(vecs[k].br));
            chk($sformatf("v%0d illegal", k), 32'(rsp_illegal), 32'(vecs[k].ill));
            chk($sformatf("v%0d resp ctrl", k), 32'(alu_ctrl), 32'd0);
            chk($sformatf("v%0d resp in1", k), alu_in1, 32'd0);
            tick();
            chk($sformatf("v%0d done rsp_valid", k), 32'(rsp_valid), 32'd0);
            chk($sformatf("v%0d done req_ready", k), 32'(req_ready), 32'd1);
        end

        // illegal opcode 0x3F held under backpressure
        send(32'hFC000000, 32'd5, 32'd6, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("ill rsp_valid", 32'(rsp_valid), 32'd1);
            chk("ill illegal", 32'(rsp_illegal), 32'd1);
            chk("ill result", rsp_result, 32'd0);
            chk("ill ctrl", 32'(alu_ctrl), 32'd0);
            chk("ill req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("ill drain rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ill drain req_ready", 32'(req_ready), 32'd1);

        // legal op held, with a new request ignored while busy
        send(32'h00221820, 32'd20, 32'd22, 1'b0);
        tick();
        req_valid = 1'b1;
        req_instr = 32'h00000022;
        for (int c = 0; c < 4; c++) begin
            chk("hold rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold result", rsp_result, 32'd42);
            chk("hold req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = 1'b0;

        // asynchronous reset while a response is pending
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst mid-resp rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst mid-resp req_ready", 32'(req_ready), 32'd1);
        chk("rst mid-resp ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst mid-resp result", rsp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // asynchronous reset during ISSUE
        send(32'h00000025, 32'h0000F000, 32'h0000000F, 1'b1);
        chk("pre-rst issue ctrl", 32'(alu_ctrl), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst mid-issue ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst mid-issue in1", alu_in1, 32'd0);
        chk("rst mid-issue req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post-rst rsp_valid", 32'(rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Instruction-side initiator for the 32-bit ALU: accepts one decoded-instruction request at a time (instruction word plus register operands), derives the 4-bit ALU control code and second operand, and drives the ALU for exactly one cycle. It captures the ALU result and zero flag and returns them, plus a branch decision, through a valid/ready response port. It sits between the register-read stage and the ALU/writeback path.

## Interface
- No parameters. Data width is fixed at 32, control width at 4.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_instr  in  32  instruction word: opcode [31:26], funct [5:0], imm [15:0].
- req_rs  in  32  rs register value.
- req_rt  in  32  rt register value.
- alu_in1  out  32  ALU operand 1 (registered).
- alu_in2  out  32  ALU operand 2 (registered).
- alu_ctrl  out  4  ALU control (registered). Codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- alu_out  in  32  ALU result, combinational from alu_in1/alu_in2/alu_ctrl.
- alu_zero  in  1  ALU zero flag (alu_out == 0).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  32  captured ALU result.
- rsp_zero  out  1  captured zero flag.
- rsp_br_taken  out  1  branch decision (BEQ/BNE only, else 0).
- rsp_illegal  out  1  opcode/funct not supported.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE on handshake with a legal decode.
  - IDLE → RESP on handshake with an illegal decode.
  - ISSUE → RESP unconditionally.
  - RESP → IDLE when rsp_ready = 1.
- Handshake: occurs when req_valid & req_ready. req_ready = 1 only in IDLE.
- At handshake, the block registers alu_in1 = req_rs, alu_in2 = the selected operand, alu_ctrl = the decoded code, and a branch-kind flag (none/eq/ne).
- R-type decode (opcode 0x00), alu_in2 = rt:
  - funct 0x20/0x21 → ADD
  - funct 0x22/0x23 → SUB
  - funct 0x24 → AND
  - funct 0x25 → OR
  - funct 0x27 → NOR
  - funct 0x2A → SLT
- I-type decode:
  - 0x08/0x09/0x23/0x2B → ADD, sign-extended imm.
  - 0x0A → SLT, sign-extended imm.
  - 0x0C → AND, zero-extended imm.
  - 0x0D → OR, zero-extended imm.
  - 0x04 → SUB, in2 = rt, kind eq.
  - 0x05 → SUB, in2 = rt, kind ne.
- Illegal decode (any other opcode, or an R-type funct not listed):
  - No ALU issue.
  - rsp_result = 0, rsp_zero = 0, rsp_br_taken = 0, rsp_illegal = 1.
- End of ISSUE: capture rsp_result = alu_out and rsp_zero = alu_zero. rsp_br_taken = alu_zero for eq, ~alu_zero for ne, else 0. rsp_illegal = 0.
- The block passes alu_out through verbatim. It applies no sign correction to SLT or overflow detection to ADD/SUB.
- Outside ISSUE, alu_in1, alu_in2 and alu_ctrl are driven to 0 (ctrl = AND).

## Timing
- Reset values: FSM = IDLE, req_ready = 1, rsp_valid = 0, all rsp_* = 0, alu_in1 = alu_in2 = 0, alu_ctrl = 0000.
- Legal op: handshake at edge E0; ISSUE during cycle E0–E1; rsp_valid = 1 from edge E1 onward (2-cycle request-to-response latency counting the accept edge).
- Illegal op: rsp_valid = 1 from edge E0 (no ISSUE cycle).
- rsp_* are stable while rsp_valid = 1 and rsp_ready = 0; hold is unbounded.
- Response accepted at the edge where rsp_valid & rsp_ready. rsp_valid drops and req_ready rises at that same edge.
- No request/response overlap. Maximum throughput is one legal op per 3 cycles with rsp_ready held high.
- req_* are sampled only at the handshake edge; changes at any other time are ignored.
- rst_n low at any time, including ISSUE or RESP: all registers return to reset values immediately. Any pending response is discarded.

## Test plan
- Reset mid-RESP: rst_n low while rsp_valid = 1 → rsp_valid = 0, req_ready = 1 and alu_ctrl = 0000 immediately, with no clock edge needed.
- ADD R-type: instr 0x00221820, rs = 5, rt = 7, rsp_ready = 1 → alu_ctrl = 0010 in ISSUE; rsp_result = 12, rsp_zero = 0, rsp_illegal = 0; rsp_valid 2 cycles after accept.
- ADDI with negative imm: opcode 0x08, imm 0xFFFF, rs = 1 → alu_in2 = 0xFFFFFFFF, rsp_result = 0, rsp_zero = 1.
- ORI zero-extend: opcode 0x0D, imm 0x8000, rs = 0x00010000 → alu_in2 = 0x00008000, alu_ctrl = 0001, rsp_result = 0x00018000.
- Branches:
  - BEQ with rs = rt = 9 → alu_ctrl = 0110, rsp_zero = 1, rsp_br_taken = 1.
  - BNE with the same operands → rsp_br_taken = 0.
- Illegal op with backpressure: opcode 0x3F → rsp_valid on the accept edge, rsp_illegal = 1, rsp_result = 0, alu_ctrl stays 0000. Hold rsp_ready = 0 for 5 cycles → outputs stable and req_ready = 0 throughout.
